// File: rtl/fifo_drain_serializer.sv
// fifo_drain_serializer: pops words from the FIFO read port and shifts them out bit-serially.
// Define FIFO_DRAIN_PARITY_EN to append an even-parity bit after each word's data bits.
module fifo_drain_serializer #(
    parameter int DATA_WIDTH = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dread,
    output logic                  fifo_r_en,
    input  logic                  ser_ready,
    output logic                  ser_valid,
    output logic                  ser_data,
    output logic                  ser_last,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_count
);
    localparam int BW = $clog2(DATA_WIDTH + 1);
`ifdef FIFO_DRAIN_PARITY_EN
    localparam int NBITS = DATA_WIDTH + 1;
`else
    localparam int NBITS = DATA_WIDTH;
`endif
    localparam logic [BW-1:0] LAST = BW'(NBITS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT} state_t;
    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [BW-1:0]         bit_cnt;
    logic                  head;
    logic                  data_bit;

    assign head = MSB_FIRST ? shift_reg[DATA_WIDTH-1] : shift_reg[0];

`ifdef FIFO_DRAIN_PARITY_EN
    logic parity;
    always_ff @(posedge clk) begin
        if (reset)
            parity <= 1'b0;
        else if (state == FETCH)
            parity <= ^fifo_dread;
    end
    assign data_bit = (bit_cnt == BW'(DATA_WIDTH)) ? parity : head;
`else
    assign data_bit = head;
`endif

    // reset gates the pop so the FIFO is never drained while we are held
    assign fifo_r_en = (state == IDLE) && !fifo_empty && !reset;
    assign ser_valid = state == SHIFT;
    assign busy      = state != IDLE;
    assign ser_last  = ser_valid && (bit_cnt == LAST);
    assign ser_data  = ser_valid && data_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            word_count <= '0;
        end else begin
            case (state)
                IDLE: if (!fifo_empty) state <= FETCH;
                FETCH: begin
                    shift_reg <= fifo_dread;
                    bit_cnt   <= '0;
                    state     <= SHIFT;
                end
                SHIFT: if (ser_ready) begin
                    shift_reg <= MSB_FIRST ? shift_reg << 1 : shift_reg >> 1;
                    bit_cnt   <= bit_cnt + 1'b1;
                    if (ser_last) begin
                        word_count <= word_count + 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
